// File: rtl/gradient_magnitude_iter.sv
// Sequential gradient magnitude: a^2+b^2, then a bit-serial restoring square root, saturated.
// Optional build macro MAG_ROUND_EN rounds the root to nearest instead of truncating.
module gradient_magnitude_iter #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       mag,
  output logic                   sat
);

  localparam int unsigned S  = 2 * IN_W;
  localparam int unsigned R  = IN_W;
  localparam int unsigned RW = R + 1;
  localparam int unsigned TW = R + 3;
  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [RW-1:0] MagMax = RW'((2 ** OUT_W) - 1);

  typedef enum logic [1:0] {StIdle, StSquare, StRoot, StDone} state_e;

  state_e state_q, state_d;

  logic signed [IN_W-1:0] a_q, b_q;
  logic [S-1:0]           val_q;
  logic [RW-1:0]          rem_q;
  logic [R-1:0]           root_q;
  logic [CW-1:0]          cnt_q;
  logic [OUT_W-1:0]       mag_q;
  logic                   sat_q;

  logic signed [S-1:0] a_ext, b_ext, a_sq, b_sq;
  logic [S-1:0]        val_sum;
  logic [TW-1:0]       rem_sh, trial;
  logic                take;
  logic [RW-1:0]       rem_nx;
  logic [R-1:0]        root_nx;
  logic [RW-1:0]       root_fin;
  logic                sat_fin;
  logic [OUT_W-1:0]    mag_fin;

  // Squares are non-negative, so the sum is safe as unsigned even for a = b = -2^(IN_W-1).
  always_comb begin
    a_ext   = S'(a_q);
    b_ext   = S'(b_q);
    a_sq    = a_ext * a_ext;
    b_sq    = b_ext * b_ext;
    val_sum = $unsigned(a_sq) + $unsigned(b_sq);
  end

  // The true remainder never exceeds 2*root, so RW bits hold it after the subtract.
  always_comb begin
    rem_sh  = {rem_q, val_q[S-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    take    = (rem_sh >= trial);
    rem_nx  = take ? RW'(rem_sh - trial) : RW'(rem_sh);
    root_nx = {root_q[R-2:0], take};
`ifdef MAG_ROUND_EN
    root_fin = {1'b0, root_nx} + RW'(rem_nx > {1'b0, root_nx});
`else
    root_fin = {1'b0, root_nx};
`endif
    sat_fin = (root_fin > MagMax);
    mag_fin = sat_fin ? {OUT_W{1'b1}} : root_fin[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StSquare;
      StSquare: state_d = StRoot;
      StRoot:   if (cnt_q == '0) state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      val_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      mag_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        StSquare: begin
          val_q  <= val_sum;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= CW'(R - 1);
        end
        StRoot: begin
          val_q  <= val_q << 2;
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q - 1'b1;
          // Result registers move only on the transition into DONE.
          if (cnt_q == '0) begin
            mag_q <= mag_fin;
            sat_q <= sat_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign mag = mag_q;
  assign sat = sat_q;

endmodule
